// File: rtl/memstage_pkg.sv
// rtl/memstage_pkg.sv - shared encodings and helpers for the data-memory stage
package memstage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WCNT_W = $clog2(8);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << a;
      SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/memstage_ext_if.sv
// rtl/memstage_ext_if.sv - request/done bus between the pipeline and the memory stage
interface memstage_ext_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Mem_Req;
  logic              Mem_WrEn;
  logic [1:0]        Mem_Size;
  logic              Mem_Unsigned;
  logic [ADDR_W-1:0] ALU_MEM_Addr;
  logic [DATA_W-1:0] MEM_DataIn;
  logic [DATA_W-1:0] MEM_DataOut;
  logic              Mem_Busy;
  logic              Mem_Done;
  logic              Mem_Misalign;

  modport master (
    output Mem_Req, Mem_WrEn, Mem_Size, Mem_Unsigned, ALU_MEM_Addr, MEM_DataIn,
    input  MEM_DataOut, Mem_Busy, Mem_Done, Mem_Misalign
  );

  modport slave (
    input  Mem_Req, Mem_WrEn, Mem_Size, Mem_Unsigned, ALU_MEM_Addr, MEM_DataIn,
    output MEM_DataOut, Mem_Busy, Mem_Done, Mem_Misalign
  );
endinterface

// File: rtl/memstage_ext_ram_be.sv
// rtl/memstage_ext_ram_be.sv - single-port synchronous RAM with byte enables and registered read
module ram_be #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memstage_ext.sv
// rtl/memstage_ext.sv - multi-cycle data-memory stage with wait states, sub-word access and misalign detection
module memstage_ext
  import memstage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           reset,
  memstage_ext_if.slave bus
);

  state_t            state, state_nx;
  logic [WCNT_W-1:0] wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              we_q, uns_q, mis_q;
  logic              done_q, mis_out_q;
  logic [DATA_W-1:0] data_out_q;
  logic              accept;
  logic              ram_en, ram_we;
  logic [3:0]        ram_be_v;
  logic [31:0]       wdata_rep, rdata, shifted, load_val;
  logic              unused_addr_hi;

  assign accept         = (state == ST_IDLE) && bus.Mem_Req;
  assign unused_addr_hi = ^addr_q[ADDR_W-1:DEPTH_LOG2+2];

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.Mem_Req) state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wcnt == '0) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      done_q     <= 1'b0;
      mis_out_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state     <= state_nx;
      done_q    <= (state == ST_RESP);
      mis_out_q <= (state == ST_RESP) && mis_q;
      if (accept) begin
        wcnt <= (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
      end else if (state == ST_WAIT && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      if (state == ST_RESP && !we_q && !mis_q) data_out_q <= load_val;
    end
  end

  // request fields are held for the whole access so the bus may change freely once accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.ALU_MEM_Addr;
      wdata_q <= bus.MEM_DataIn;
      size_q  <= bus.Mem_Size;
      we_q    <= bus.Mem_WrEn;
      uns_q   <= bus.Mem_Unsigned;
      mis_q   <= misaligned(bus.Mem_Size, bus.ALU_MEM_Addr[1:0]);
    end
  end

  always_comb begin
    wdata_rep = wdata_q;
    case (size_q)
      SZ_BYTE: wdata_rep = {4{wdata_q[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata_q[15:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  always_comb begin
    shifted  = rdata >> {addr_q[1:0], 3'b000};
    load_val = rdata;
    case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = rdata;
    endcase
  end

  // reset in the ACCESS cycle must not leave a partially committed store behind
  assign ram_en   = (state == ST_ACCESS);
  assign ram_be_v = mis_q ? 4'b0000 : byte_en(size_q, addr_q[1:0]);
  assign ram_we   = ram_en && we_q && !mis_q && !reset;

  ram_be #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be_v),
    .addr  (addr_q[DEPTH_LOG2+1:2]),
    .wdata (wdata_rep),
    .rdata (rdata)
  );

  assign bus.MEM_DataOut  = data_out_q;
  assign bus.Mem_Busy     = (state != ST_IDLE);
  assign bus.Mem_Done     = done_q;
  assign bus.Mem_Misalign = mis_out_q;

endmodule
